cxd_sched: RTL and testbench

//  Schedules CX/D pairs from the arrange_cell chain into the MQ coder.

---
 rtl/cxd_sched.sv | 161 ++++++++++++++++
 tb/tb_cxd_sched.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/cxd_sched.sv
// CX/D scheduler: packs valid arrange-cell lanes into a FIFO on BPC ticks and
// feeds the MQ coder one pair per cycle, with end-of-code-block drain sequencing.
module cxd_sched #(
  parameter int LANES = 4,
  parameter int DEPTH = 16,
  parameter int CW    = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CNT_W = AW + 1
) (
  input  logic                  clk_dwt,
  input  logic                  rst,
  input  logic                  rst_syn,
  input  logic                  pos_clk_bpc,
  input  logic [LANES*CW-1:0]   lane_cxd,
  input  logic [LANES-1:0]      lane_vld,
  input  logic                  flush_req,
  input  logic                  mq_rdy,
  output logic                  stall_vld,
  output logic [CW-1:0]         cxd_out,
  output logic                  cxd_out_vld,
  output logic                  flush_done,
  output logic [CNT_W-1:0]      fifo_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] STALL_TH = CNT_W'(DEPTH - LANES);

  state_t                state_q, state_d;
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  stall_q, stall_d;
  logic [CW-1:0]         mem_q [DEPTH];
  logic [CW-1:0]         mem_d [DEPTH];

  logic                  wr_en_s;
  logic                  pop_s;
  logic [CNT_W-1:0]      n_s;
  logic [CNT_W-1:0]      wr_add_s;
  logic [AW-1:0]         off_s;

  assign wr_en_s = pos_clk_bpc & ~stall_q & (state_q != DRAIN);
  assign pop_s   = (cnt_q != '0) & mq_rdy;

  always_comb begin
    n_s = '0;
    for (int i = 0; i < LANES; i++) begin
      n_s = n_s + CNT_W'(lane_vld[i]);
    end
    wr_add_s = wr_en_s ? n_s : '0;
  end

  // State register.
  always_ff @(posedge clk_dwt or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a flush with data still queued in IDLE drains like RUN.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (flush_req) begin
          state_d = (cnt_d == '0) ? DONE : DRAIN;
        end else if (wr_add_s != '0) begin
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        state_d = flush_req ? DRAIN : RUN;
      end
      DRAIN: begin
        state_d = (cnt_d == '0) ? DONE : DRAIN;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (rst_syn) begin
      state_d = IDLE;
    end
  end

  // Outputs decoded from registered state and occupancy.
  always_comb begin
    flush_done  = (state_q == DONE);
    cxd_out_vld = (cnt_q != '0);
    cxd_out     = (cnt_q != '0) ? mem_q[rd_ptr_q] : '0;
    stall_vld   = stall_q;
    fifo_cnt    = cnt_q;
  end

  // Datapath: lanes packed lane0-first at wr_ptr, invalid lanes skipped.
  always_comb begin
    mem_d = mem_q;
    off_s = '0;
    if (wr_en_s) begin
      for (int i = 0; i < LANES; i++) begin
        if (lane_vld[i]) begin
          mem_d[wr_ptr_q + off_s] = lane_cxd[i*CW +: CW];
          off_s = off_s + AW'(1);
        end
      end
    end
    wr_ptr_d = wr_ptr_q + AW'(wr_add_s);
    rd_ptr_d = rd_ptr_q + AW'(pop_s);
    cnt_d    = cnt_q + wr_add_s - CNT_W'(pop_s);
    if (rst_syn) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_d[i] = '0;
      end
    end
  end

  // Stall leaves room for a full tick of lanes at every accepted write.
  always_comb begin
    stall_d = (cnt_d > STALL_TH) | (state_d == DRAIN);
    if (rst_syn) begin
      stall_d = 1'b0;
    end
  end

  always_ff @(posedge clk_dwt or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      stall_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      stall_q  <= stall_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

endmodule

// File: tb/tb_cxd_sched.sv
// Directed bench for cxd_sched: reset, packing, stall threshold, drain and a
// scoreboarded random stretch.
module tb_cxd_sched;

  logic        clk_dwt = 1'b0;
  logic        rst;
  logic        rst_syn;
  logic        pos_clk_bpc;
  logic [31:0] lane_cxd;
  logic [3:0]  lane_vld;
  logic        flush_req;
  logic        mq_rdy;
  logic        stall_vld;
  logic [7:0]  cxd_out;
  logic        cxd_out_vld;
  logic        flush_done;
  logic [4:0]  fifo_cnt;

  int checks   = 0;
  int failures = 0;

  cxd_sched dut (
    .clk_dwt     (clk_dwt),
    .rst         (rst),
    .rst_syn     (rst_syn),
    .pos_clk_bpc (pos_clk_bpc),
    .lane_cxd    (lane_cxd),
    .lane_vld    (lane_vld),
    .flush_req   (flush_req),
    .mq_rdy      (mq_rdy),
    .stall_vld   (stall_vld),
    .cxd_out     (cxd_out),
    .cxd_out_vld (cxd_out_vld),
    .flush_done  (flush_done),
    .fifo_cnt    (fifo_cnt)
  );

  always #5 clk_dwt = ~clk_dwt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_dwt);
    #1;
  endtask

  logic [7:0] q[$];
  logic [7:0] d8;
  int         cnt_m;
  int         n_m;
  bit         stall_m;
  bit         pop_m;

  initial begin
    rst = 1'b1; rst_syn = 1'b0; pos_clk_bpc = 1'b0; lane_cxd = 32'h0;
    lane_vld = 4'h0; flush_req = 1'b0; mq_rdy = 1'b0;
    cyc(); cyc();
    chk("rst_cnt", 32'(fifo_cnt), 32'd0);
    chk("rst_vld", 32'(cxd_out_vld), 32'd0);
    chk("rst_out", 32'(cxd_out), 32'd0);
    chk("rst_stall", 32'(stall_vld), 32'd0);
    chk("rst_done", 32'(flush_done), 32'd0);
    rst = 1'b0;
    cyc();

    // 1: reset mid-stream at occupancy 7
    pos_clk_bpc = 1'b1; lane_vld = 4'hF; lane_cxd = 32'h04030201;
    cyc();
    lane_vld = 4'h7;
    cyc();
    pos_clk_bpc = 1'b0;
    chk("t1_cnt7", 32'(fifo_cnt), 32'd7);
    chk("t1_head", 32'(cxd_out), 32'h01);
    #2 rst = 1'b1;
    #1;
    chk("t1_async_cnt", 32'(fifo_cnt), 32'd0);
    chk("t1_async_vld", 32'(cxd_out_vld), 32'd0);
    chk("t1_async_out", 32'(cxd_out), 32'd0);
    chk("t1_async_stall", 32'(stall_vld), 32'd0);
    chk("t1_async_done", 32'(flush_done), 32'd0);
    cyc();
    rst = 1'b0;
    flush_req = 1'b1;
    cyc();
    flush_req = 1'b0;
    chk("t1_idle_flush_done", 32'(flush_done), 32'd1);
    cyc();
    chk("t1_done_pulse_end", 32'(flush_done), 32'd0);

    // 2: sparse lanes packed in order, drained with mq_rdy=1
    mq_rdy = 1'b1; pos_clk_bpc = 1'b1; lane_vld = 4'b1011; lane_cxd = 32'h44332211;
    cyc();
    pos_clk_bpc = 1'b0;
    chk("t2_out0", 32'(cxd_out), 32'h11);
    chk("t2_vld0", 32'(cxd_out_vld), 32'd1);
    cyc();
    chk("t2_out1", 32'(cxd_out), 32'h22);
    cyc();
    chk("t2_out2", 32'(cxd_out), 32'h44);
    cyc();
    chk("t2_vld_end", 32'(cxd_out_vld), 32'd0);
    chk("t2_out_end", 32'(cxd_out), 32'd0);

    // 3: fill to 16 with mq_rdy=0, fifth tick ignored
    mq_rdy = 1'b0; pos_clk_bpc = 1'b1; lane_vld = 4'hF;
    lane_cxd = 32'hA3A2A1A0; cyc();
    chk("t3_cnt4", 32'(fifo_cnt), 32'd4);
    lane_cxd = 32'hB3B2B1B0; cyc();
    chk("t3_cnt8", 32'(fifo_cnt), 32'd8);
    lane_cxd = 32'hC3C2C1C0; cyc();
    chk("t3_cnt12", 32'(fifo_cnt), 32'd12);
    chk("t3_stall12", 32'(stall_vld), 32'd0);
    lane_cxd = 32'hD3D2D1D0; cyc();
    chk("t3_cnt16", 32'(fifo_cnt), 32'd16);
    chk("t3_stall16", 32'(stall_vld), 32'd1);
    lane_cxd = 32'hE3E2E1E0; cyc();
    pos_clk_bpc = 1'b0;
    chk("t3_ignored_cnt", 32'(fifo_cnt), 32'd16);
    chk("t3_head", 32'(cxd_out), 32'hA0);

    // 4: stall release at 12, re-stall on tick plus pop
    mq_rdy = 1'b1;
    cyc(); cyc(); cyc();
    chk("t4_cnt13", 32'(fifo_cnt), 32'd13);
    chk("t4_stall13", 32'(stall_vld), 32'd1);
    cyc();
    chk("t4_cnt12", 32'(fifo_cnt), 32'd12);
    chk("t4_stall12", 32'(stall_vld), 32'd0);
    chk("t4_head_b0", 32'(cxd_out), 32'hB0);
    pos_clk_bpc = 1'b1; lane_cxd = 32'hF3F2F1F0; lane_vld = 4'hF;
    cyc();
    pos_clk_bpc = 1'b0;
    chk("t4_cnt15", 32'(fifo_cnt), 32'd15);
    chk("t4_stall15", 32'(stall_vld), 32'd1);

    // 5: drain from occupancy 5
    for (int i = 0; i < 10; i++) cyc();
    chk("t5_cnt5", 32'(fifo_cnt), 32'd5);
    chk("t5_head_d3", 32'(cxd_out), 32'hD3);
    flush_req = 1'b1;
    cyc();
    flush_req = 1'b0;
    chk("t5_stall_drain", 32'(stall_vld), 32'd1);
    chk("t5_cnt4", 32'(fifo_cnt), 32'd4);
    chk("t5_head_f0", 32'(cxd_out), 32'hF0);
    chk("t5_done_early", 32'(flush_done), 32'd0);
    cyc(); cyc(); cyc();
    chk("t5_cnt1", 32'(fifo_cnt), 32'd1);
    chk("t5_head_f3", 32'(cxd_out), 32'hF3);
    chk("t5_done_pre", 32'(flush_done), 32'd0);
    cyc();
    chk("t5_done", 32'(flush_done), 32'd1);
    chk("t5_cnt0", 32'(fifo_cnt), 32'd0);
    cyc();
    chk("t5_done_end", 32'(flush_done), 32'd0);
    chk("t5_stall_end", 32'(stall_vld), 32'd0);
    flush_req = 1'b1;
    cyc();
    flush_req = 1'b0;
    chk("t5_idle_again", 32'(flush_done), 32'd1);
    cyc();

    // 6: random lanes and mq_rdy against a queue model
    cnt_m = 0; stall_m = 1'b0;
    for (int t = 0; t < 40; t++) begin
      pos_clk_bpc = 1'b1;
      lane_vld = 4'($urandom_range(0, 15));
      lane_cxd = $urandom;
      mq_rdy = 1'($urandom_range(0, 1));
      #1;
      chk("t6_vld", 32'(cxd_out_vld), 32'(q.size() != 0));
      if (q.size() != 0) chk("t6_order", 32'(cxd_out), 32'(q[0]));
      pop_m = (q.size() != 0) && mq_rdy;
      if (pop_m) void'(q.pop_front());
      n_m = 0;
      if (!stall_m) begin
        for (int i = 0; i < 4; i++) begin
          if (lane_vld[i]) begin
            d8 = lane_cxd[i*8 +: 8];
            q.push_back(d8);
            n_m++;
          end
        end
      end
      cnt_m = cnt_m + n_m - int'(pop_m);
      stall_m = (cnt_m > 12);
      cyc();
      chk("t6_cnt", 32'(fifo_cnt), 32'(cnt_m));
      chk("t6_stall", 32'(stall_vld), 32'(stall_m));
      chk("t6_cnt_le_depth", 32'(fifo_cnt <= 5'd16), 32'd1);
    end
    pos_clk_bpc = 1'b0; mq_rdy = 1'b1;
    for (int t = 0; t < 40 && q.size() != 0; t++) begin
      chk("t6_drain_order", 32'(cxd_out), 32'(q[0]));
      void'(q.pop_front());
      cyc();
    end
    chk("t6_model_empty", 32'(q.size()), 32'd0);
    chk("t6_dut_empty", 32'(fifo_cnt), 32'd0);
    chk("t6_vld_empty", 32'(cxd_out_vld), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
